alu_secuencial: RTL

Registered, handshaked successor to the combinational ALU. It is parametrised in width and extends the op set to eight operations, adding XOR, logical shifts and an optional multi-cycle serial multiply. It also produces registered N/Z/C/V status flags. It sits between the operand registers and the result/display path, and is started by a one-cycle `inicio` strobe from the control FSM.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_secuencial_if.sv | 23 ++
 rtl/alu_mult_serie.sv | 52 +++++
 rtl/alu_secuencial.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_SUMA  = 3'b000,
      OP_RESTA = 3'b001,
      OP_OR    = 3'b010,
      OP_AND   = 3'b011,
      OP_XOR   = 3'b100,
      OP_SHL   = 3'b101,
      OP_SHR   = 3'b110,
      OP_MUL   = 3'b111
   } op_alu_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      REPOSO = 1'b0,
      MULT   = 1'b1
   } estado_alu_t;

endpackage

// File: rtl/alu_secuencial_if.sv
// Operand/handshake/result bundle between the control path and the sequential ALU.
interface alu_secuencial_if #(parameter int N_BITS = 8) ();

   logic [N_BITS-1:0] entrada_a;
   logic [N_BITS-1:0] entrada_b;
   logic [2:0]        operacion;
   logic              inicio;
   logic              ocupado;
   logic              listo;
   logic [N_BITS-1:0] resultado;
   logic [3:0]        flags;

   modport master (
      output entrada_a, entrada_b, operacion, inicio,
      input  ocupado, listo, resultado, flags
   );

   modport slave (
      input  entrada_a, entrada_b, operacion, inicio,
      output ocupado, listo, resultado, flags
   );

endinterface

// File: rtl/alu_mult_serie.sv
// Serial shift-add multiplier: one partial product per cycle, N_BITS cycles per product.
module alu_mult_serie #(
   parameter int N_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inicio,
   input  logic [N_BITS-1:0]     a,
   input  logic [N_BITS-1:0]     b,
   output logic [2*N_BITS-1:0]   producto,
   output logic                  fin
);

   localparam int CW = $clog2(N_BITS);

   logic [2*N_BITS-1:0] acum;
   logic [2*N_BITS-1:0] acum_sig;
   logic [2*N_BITS-1:0] multiplicando;
   logic [N_BITS-1:0]   multiplicador;
   logic [CW-1:0]       cuenta;
   logic                activo;

   // producto exposes the value the last step will write, so the caller can register it on that same edge
   assign acum_sig = multiplicador[0] ? (acum + multiplicando) : acum;
   assign producto = acum_sig;
   assign fin      = activo && (cuenta == CW'(N_BITS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acum          <= '0;
         multiplicando <= '0;
         multiplicador <= '0;
         cuenta        <= '0;
         activo        <= 1'b0;
      end else if (inicio) begin
         acum          <= '0;
         multiplicando <= {{N_BITS{1'b0}}, a};
         multiplicador <= b;
         cuenta        <= '0;
         activo        <= 1'b1;
      end else if (activo) begin
         acum          <= acum_sig;
         multiplicando <= multiplicando << 1;
         multiplicador <= multiplicador >> 1;
         cuenta        <= cuenta + CW'(1);
         if (fin) begin
            activo <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_secuencial.sv
// Registered, handshaked ALU with N/Z/C/V flags. Define ALU_MUL_EN to build op 111 as a serial multiply;
// otherwise op 111 completes in one cycle with a zero result.
module alu_secuencial
   import alu_pkg::*;
#(
   parameter int N_BITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   alu_secuencial_if.slave  bus
);

   op_alu_t           op;
   logic [N_BITS-1:0] a;
   logic [N_BITS-1:0] b;
   logic [N_BITS:0]   suma;
   logic [N_BITS-1:0] resta;
   logic [N_BITS:0]   shl_w;
   logic [N_BITS:0]   shr_w;
   logic [N_BITS-1:0] res_alu;
   logic              c_alu;
   logic              v_alu;
   logic [N_BITS-1:0] res_fin;
   logic              c_fin;
   logic              v_fin;
   logic              completa;
   logic [N_BITS-1:0] resultado_q;
   logic [3:0]        flags_q;
   logic              listo_q;

   assign op    = op_alu_t'(bus.operacion);
   assign a     = bus.entrada_a;
   assign b     = bus.entrada_b;
   assign suma  = {1'b0, a} + {1'b0, b};
   assign resta = a - b;

   // One guard bit on each side catches the last bit shifted out; oversized amounts shift everything away
   assign shl_w = {1'b0, a} << b;
   assign shr_w = {a, 1'b0} >> b;

   always_comb begin
      res_alu = '0;
      c_alu   = 1'b0;
      v_alu   = 1'b0;
      case (op)
         OP_SUMA: begin
            res_alu = suma[N_BITS-1:0];
            c_alu   = suma[N_BITS];
            v_alu   = (a[N_BITS-1] == b[N_BITS-1]) && (suma[N_BITS-1] != a[N_BITS-1]);
         end
         OP_RESTA: begin
            res_alu = resta;
            c_alu   = (a >= b);
            v_alu   = (a[N_BITS-1] != b[N_BITS-1]) && (resta[N_BITS-1] != a[N_BITS-1]);
         end
         OP_OR:   res_alu = a | b;
         OP_AND:  res_alu = a & b;
         OP_XOR:  res_alu = a ^ b;
         OP_SHL: begin
            res_alu = shl_w[N_BITS-1:0];
            c_alu   = shl_w[N_BITS];
         end
         OP_SHR: begin
            res_alu = shr_w[N_BITS:1];
            c_alu   = shr_w[0];
         end
         default: ;
      endcase
   end

`ifdef ALU_MUL_EN
   estado_alu_t         estado;
   estado_alu_t         estado_sig;
   logic                arranque;
   logic                carga;
   logic                carga_mult;
   logic [2*N_BITS-1:0] producto;
   logic                fin;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado <= REPOSO;
      end else begin
         estado <= estado_sig;
      end
   end

   // inicio is only looked at in REPOSO, so strobes during a multiply fall on the floor
   always_comb begin
      estado_sig = estado;
      arranque   = 1'b0;
      carga      = 1'b0;
      carga_mult = 1'b0;
      case (estado)
         REPOSO: begin
            if (bus.inicio) begin
               if (op == OP_MUL) begin
                  arranque   = 1'b1;
                  estado_sig = MULT;
               end else begin
                  carga = 1'b1;
               end
            end
         end
         MULT: begin
            if (fin) begin
               carga_mult = 1'b1;
               estado_sig = REPOSO;
            end
         end
         default: estado_sig = REPOSO;
      endcase
   end

   alu_mult_serie #(.N_BITS(N_BITS)) u_mult (
      .clk      (clk),
      .reset    (reset),
      .inicio   (arranque),
      .a        (a),
      .b        (b),
      .producto (producto),
      .fin      (fin)
   );

   assign bus.ocupado = (estado == MULT);
   assign completa    = carga | carga_mult;

   always_comb begin
      res_fin = res_alu;
      c_fin   = c_alu;
      v_fin   = v_alu;
      if (carga_mult) begin
         res_fin = producto[N_BITS-1:0];
         c_fin   = |producto[2*N_BITS-1:N_BITS];
         v_fin   = 1'b0;
      end
   end
`else
   assign bus.ocupado = 1'b0;
   assign completa    = bus.inicio;
   assign res_fin     = res_alu;
   assign c_fin       = c_alu;
   assign v_fin       = v_alu;
`endif

   // Result and flags move together and only on a completion edge
   always_ff @(posedge clk) begin
      if (reset) begin
         resultado_q <= '0;
         flags_q     <= 4'b0000;
         listo_q     <= 1'b0;
      end else begin
         listo_q <= completa;
         if (completa) begin
            resultado_q     <= res_fin;
            flags_q[FLAG_N] <= res_fin[N_BITS-1];
            flags_q[FLAG_Z] <= (res_fin == '0);
            flags_q[FLAG_C] <= c_fin;
            flags_q[FLAG_V] <= v_fin;
         end
      end
   end

   assign bus.resultado = resultado_q;
   assign bus.flags     = flags_q;
   assign bus.listo     = listo_q;

endmodule
